// File: rtl/idli_pkg.sv
// idli_pkg: shared types and SQI flash controller constants.
package idli_pkg;
  typedef logic [15:0] data_t;
  typedef logic [3:0]  slice_t;
  typedef logic [1:0]  ctr_t;
  typedef enum logic { MEM_LOAD, MEM_STORE } mem_op_t;
  typedef enum logic [2:0] {
    SQI_IDLE, SQI_CMD, SQI_ADDR, SQI_DUMMY, SQI_DATA, SQI_END
  } sqi_state_t;
  typedef enum logic [1:0] { TXN_FETCH, TXN_LOAD, TXN_STORE } txn_t;
  localparam logic [7:0] SQI_CMD_READ      = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE     = 8'h02;
  localparam int         SQI_CMD_NIBBLES   = 2;
  localparam int         SQI_ADDR_NIBBLES  = 6;
  localparam int         SQI_DUMMY_NIBBLES = 2;
  localparam int         SQI_DATA_NIBBLES  = 4;

  // Word address becomes a 24-bit byte address; nibble 0 is the most significant.
  function automatic slice_t addr_nibble(input data_t addr, input logic [2:0] idx);
    logic [23:0] byte_addr;
    byte_addr = {7'b0, addr, 1'b0};
    return byte_addr[5'd20 - {idx, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/idli_sqi_arb.sv
// idli_sqi_arb: fixed-priority two-requester arbiter, grants only while idle.
module idli_sqi_arb (
  input  logic idle,
  input  logic req_hi,
  input  logic req_lo,
  output logic gnt_hi,
  output logic gnt_lo
);
  always_comb begin
    gnt_hi = idle && req_hi;
    gnt_lo = idle && req_lo && !req_hi;
  end
endmodule

// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: SQI flash/SRAM controller serving instruction fetch bursts and single-word data loads/stores.
module idli_sqi_ctrl
  import idli_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [15:0] i_fetch_addr,
  output logic        o_fetch_ack,
  output logic        o_fetch_vld,
  output logic [3:0]  o_fetch_slice,
  output logic [1:0]  o_fetch_ctr,
  input  logic        i_mem_req,
  input  logic        i_mem_op,
  input  logic [15:0] i_mem_addr,
  input  logic [3:0]  i_mem_wdata,
  output logic        o_mem_ack,
  output logic        o_mem_vld,
  output logic [3:0]  o_mem_rdata,
  output logic [1:0]  o_mem_ctr,
  output logic        o_mem_done,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_oe,
  output logic [3:0]  o_sqi_dout,
  input  logic [3:0]  i_sqi_din,
  output logic        o_busy
);
  sqi_state_t state, state_nxt;
  txn_t       txn;
  data_t      addr;
  logic [2:0] phase;
  logic       phase_last, burst, rd, st_data, mem_gnt, fetch_gnt;
  logic       rd_vld, rd_fetch;
  slice_t     rd_slice;
  ctr_t       rd_ctr;
  logic [7:0] cmd;

  idli_sqi_arb u_arb (
    .idle   (state == SQI_IDLE),
    .req_hi (i_mem_req),
    .req_lo (i_fetch_req),
    .gnt_hi (mem_gnt),
    .gnt_lo (fetch_gnt)
  );

  assign rd      = txn != TXN_STORE;
  assign st_data = state == SQI_DATA && !rd;
  assign cmd     = rd ? SQI_CMD_READ : SQI_CMD_WRITE;
  assign phase_last = (state == SQI_CMD)   ? phase == 3'(SQI_CMD_NIBBLES - 1) :
                      (state == SQI_ADDR)  ? phase == 3'(SQI_ADDR_NIBBLES - 1) :
                      (state == SQI_DUMMY) ? phase == 3'(SQI_DUMMY_NIBBLES - 1) :
                      (state == SQI_DATA)  ? phase == 3'(SQI_DATA_NIBBLES - 1) : 1'b1;
  // Only a fetch continues, and only while nobody on the data side is waiting.
  assign burst = state == SQI_DATA && phase_last && txn == TXN_FETCH && i_fetch_req && !i_mem_req;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= SQI_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SQI_IDLE:  state_nxt = (mem_gnt || fetch_gnt) ? SQI_CMD : SQI_IDLE;
      SQI_CMD:   state_nxt = phase_last ? SQI_ADDR : SQI_CMD;
      SQI_ADDR:  state_nxt = phase_last ? (rd ? SQI_DUMMY : SQI_DATA) : SQI_ADDR;
      SQI_DUMMY: state_nxt = phase_last ? SQI_DATA : SQI_DUMMY;
      SQI_DATA:  state_nxt = (phase_last && !burst) ? SQI_END : SQI_DATA;
      default:   state_nxt = SQI_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase    <= '0;
      addr     <= '0;
      txn      <= TXN_FETCH;
      rd_vld   <= 1'b0;
      rd_fetch <= 1'b0;
      rd_slice <= '0;
      rd_ctr   <= '0;
    end else begin
      phase    <= (state != state_nxt || burst || state == SQI_IDLE) ? 3'd0 : phase + 3'd1;
      addr     <= mem_gnt ? i_mem_addr : fetch_gnt ? i_fetch_addr : burst ? addr + 16'd1 : addr;
      txn      <= mem_gnt ? (i_mem_op == MEM_STORE ? TXN_STORE : TXN_LOAD) : fetch_gnt ? TXN_FETCH : txn;
      rd_vld   <= state == SQI_DATA && rd;
      rd_fetch <= txn == TXN_FETCH;
      rd_slice <= (state == SQI_DATA && rd) ? i_sqi_din : rd_slice;
      rd_ctr   <= state == SQI_DATA ? phase[1:0] : rd_ctr;
    end
  end

  always_comb begin
    o_sqi_cs_n    = state == SQI_IDLE || state == SQI_END;
    o_sqi_oe      = state == SQI_CMD || state == SQI_ADDR || st_data;
    o_sqi_dout    = state == SQI_CMD  ? (phase[0] ? cmd[3:0] : cmd[7:4]) :
                    state == SQI_ADDR ? addr_nibble(addr, phase) :
                    st_data           ? i_mem_wdata : 4'h0;
    o_busy        = state != SQI_IDLE;
    o_fetch_ack   = fetch_gnt;
    o_mem_ack     = mem_gnt;
    o_fetch_vld   = rd_vld && rd_fetch;
    o_mem_vld     = rd_vld && !rd_fetch;
    o_fetch_slice = rd_slice;
    o_mem_rdata   = rd_slice;
    o_fetch_ctr   = rd_ctr;
    o_mem_ctr     = st_data ? phase[1:0] : rd_ctr;
    o_mem_done    = state == SQI_END && txn != TXN_FETCH;
  end
endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// tb_idli_sqi_ctrl: directed bench with a small SQI memory model driving i_sqi_din.
module tb_idli_sqi_ctrl;
  logic        i_clk = 0, i_rst = 1;
  logic        i_fetch_req = 0, i_mem_req = 0, i_mem_op = 0;
  logic [15:0] i_fetch_addr = 0, i_mem_addr = 0;
  logic [3:0]  i_mem_wdata = 0, i_sqi_din;
  logic        o_fetch_ack, o_fetch_vld, o_mem_ack, o_mem_vld, o_mem_done;
  logic        o_sqi_cs_n, o_sqi_oe, o_busy;
  logic [3:0]  o_fetch_slice, o_mem_rdata, o_sqi_dout;
  logic [1:0]  o_fetch_ctr, o_mem_ctr;
  int          tests = 0, fails = 0;
  int          dcnt = 0;
  logic [31:0] dsh = 0;

  idli_sqi_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_ack(o_fetch_ack), .o_fetch_vld(o_fetch_vld),
    .o_fetch_slice(o_fetch_slice), .o_fetch_ctr(o_fetch_ctr),
    .i_mem_req(i_mem_req), .i_mem_op(i_mem_op), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .o_mem_ack(o_mem_ack), .o_mem_vld(o_mem_vld),
    .o_mem_rdata(o_mem_rdata), .o_mem_ctr(o_mem_ctr), .o_mem_done(o_mem_done),
    .o_sqi_cs_n(o_sqi_cs_n), .o_sqi_oe(o_sqi_oe), .o_sqi_dout(o_sqi_dout),
    .i_sqi_din(i_sqi_din), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Memory contents: 128 KiB, so byte address 0x20000 aliases byte 0.
  function automatic logic [7:0] mbyte(input logic [16:0] b);
    return b[7:0] ^ b[15:8] ^ {7'b0, b[16]} ^ 8'h5A;
  endfunction

  function automatic logic [3:0] exp_slice(input logic [15:0] wa, input int k);
    logic [7:0] v;
    v = mbyte({wa, k >= 2});
    return (k % 2 != 0) ? v[3:0] : v[7:4];
  endfunction

  function automatic logic [3:0] dev_nib(input int cnt, input logic [23:0] ba);
    logic [23:0] b;
    logic [7:0]  v;
    b = ba + 24'((cnt - 10) / 2);
    v = mbyte(b[16:0]);
    return ((cnt - 10) % 2 != 0) ? v[3:0] : v[7:4];
  endfunction

  // Device: shifts in cmd+addr, then after two dummy nibbles streams sequential bytes.
  always @(posedge i_clk) begin
    if (o_sqi_cs_n) dcnt <= 0;
    else begin
      if (dcnt < 8) dsh <= {dsh[27:0], o_sqi_dout};
      dcnt <= dcnt + 1;
    end
  end
  assign i_sqi_din = (dcnt >= 10) ? dev_nib(dcnt, dsh[23:0]) : 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_read(input bit fetch, input logic [15:0] a, input int words, input bit hold, input int mem_at);
    int t, nv, ncmd;
    bit prev_cs, fv, mv;
    logic [31:0] seq;
    logic [15:0] wa;
    seq = {8'h03, 7'b0, a, 1'b0};
    i_fetch_req = fetch || hold;
    if (fetch) i_fetch_addr = a;
    i_mem_req = !fetch;
    i_mem_op = 0;
    if (!fetch) i_mem_addr = a;
    #1;
    check("ack_fetch", o_fetch_ack, fetch);
    check("ack_mem", o_mem_ack, !fetch);
    nv = 0; ncmd = 0; prev_cs = 1;
    for (t = 1; t <= 200; t++) begin
      @(posedge i_clk); #1;
      i_fetch_req = fetch ? (hold || t < 10 + 4 * words) : hold;
      i_mem_req = fetch && mem_at > 0 && t >= mem_at;
      #1;
      fv = fetch ? o_fetch_vld : o_mem_vld;
      mv = fetch ? o_mem_vld : o_fetch_vld;
      if (prev_cs && !o_sqi_cs_n) ncmd++;
      prev_cs = o_sqi_cs_n;
      if (t <= 8) check("cmd_addr", o_sqi_dout, (seq >> (4 * (8 - t))) & 4'hF);
      check("oe", o_sqi_oe, t <= 8);
      check("cs_n", o_sqi_cs_n, !(t <= 10 + 4 * words));
      check("vld", fv, t >= 12 && t <= 11 + 4 * words);
      check("vld_other", mv, 0);
      check("done", o_mem_done, !fetch && t == 11 + 4 * words);
      if (o_busy) check("ack_busy", {o_fetch_ack, o_mem_ack}, 0);
      if (fv) begin
        wa = a + 16'(nv / 4);
        check("slice", fetch ? o_fetch_slice : o_mem_rdata, exp_slice(wa, nv % 4));
        check("ctr", fetch ? o_fetch_ctr : o_mem_ctr, nv % 4);
        nv++;
      end
      if (!o_busy) break;
    end
    check("len", t, 12 + 4 * words);
    check("nvld", nv, 4 * words);
    check("ncmd", ncmd, 1);
    if (fetch && mem_at > 0) check("ack_pend_mem", {o_fetch_ack, o_mem_ack}, 2'b01);
    if (hold && !fetch) check("ack_pend_fetch", {o_fetch_ack, o_mem_ack}, 2'b10);
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] wd);
    int t, ndone;
    logic [31:0] seq;
    seq = {8'h02, 7'b0, a, 1'b0};
    i_mem_req = 1; i_mem_op = 1; i_mem_addr = a;
    #1;
    check("st_ack", {o_fetch_ack, o_mem_ack}, 2'b01);
    ndone = 0;
    for (t = 1; t <= 200; t++) begin
      @(posedge i_clk); #1;
      i_mem_req = 0;
      i_mem_wdata = 4'(wd >> (4 * o_mem_ctr));
      #1;
      if (t <= 8) check("st_cmd_addr", o_sqi_dout, (seq >> (4 * (8 - t))) & 4'hF);
      if (t >= 9 && t <= 12) begin
        check("st_ctr", o_mem_ctr, t - 9);
        check("st_data", o_sqi_dout, (wd >> (4 * (t - 9))) & 4'hF);
      end
      check("st_oe", o_sqi_oe, t <= 12);
      check("st_cs_n", o_sqi_cs_n, t > 12);
      check("st_vld", o_mem_vld | o_fetch_vld, 0);
      check("st_done", o_mem_done, t == 13);
      ndone += int'(o_mem_done);
      if (!o_busy) break;
    end
    check("st_len", t, 14);
    check("st_ndone", ndone, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs_n"}, o_sqi_cs_n, 1);
    check({tag, "_oe"}, o_sqi_oe, 0);
    check({tag, "_dout"}, o_sqi_dout, 0);
    check({tag, "_flags"}, {o_busy, o_fetch_ack, o_mem_ack, o_fetch_vld, o_mem_vld, o_mem_done}, 0);
    check({tag, "_ctrs"}, {o_fetch_ctr, o_mem_ctr}, 0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    check_idle_outputs("reset");
    i_rst = 0;
    do_read(1, 16'h0010, 1, 0, 0);
    i_fetch_addr = 16'h0100;
    do_read(0, 16'h0042, 1, 1, 0);
    do_read(1, 16'h0100, 1, 0, 0);
    do_store(16'h0002, 16'h1234);
    do_read(1, 16'hFFFF, 3, 0, 0);
    do_read(1, 16'h0200, 2, 1, 16);
    do_read(0, 16'h0300, 1, 0, 0);
    i_fetch_req = 1; i_fetch_addr = 16'h0777;
    #1;
    check("rst_ack", o_fetch_ack, 1);
    repeat (5) begin @(posedge i_clk); #1; i_fetch_req = 0; end
    #1;
    check("rst_pre_busy", {o_busy, o_sqi_cs_n, o_sqi_oe}, 3'b101);
    i_rst = 1;
    #1;
    check_idle_outputs("rst_mid");
    @(posedge i_clk); #1;
    i_rst = 0;
    do_read(1, 16'h1234, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
